// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// default bus widths, requester indices and the next-owner select function.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;

    // Requester indices: 0 = processor, 1 = sprite/state updater
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Picks the owner when leaving IDLE; the caller guarantees at least one request.
    // A tie goes to the requester that did not own last (round-robin) or to requester 0.
    function automatic logic next_owner(input logic req0, input logic req1,
                                        input logic rr_en, input logic last_owner);
        if (req0 && req1) return rr_en ? ~last_owner : REQ0;
        if (req0)         return REQ0;
        return REQ1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and shared-memory signal bundle for dmem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0, req1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              wren0, wren1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, wren0, wren1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data_in, mem_wren
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, wren0, wren1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_address, mem_data_in, mem_wren
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with one-cycle read latency.
// Default build: fixed priority, requester 0 always wins and is never preempted.
// Define ARB_RR_EN for round-robin ties and MAX_HOLD preemption.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic            clock,
    input  logic            reset_btn,
    dmem_arbiter_if.slave   bus
);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state, state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                last_owner;
    logic                rvalid0_q, rvalid1_q;
    logic                issue0, issue1;
    logic                hold_at_max;
    logic                preempt0, preempt1;
    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   data_sel;
    logic                wren_sel;

    assign issue0      = (state == OWN0) && bus.req0;
    assign issue1      = (state == OWN1) && bus.req1;
    assign hold_at_max = (hold_cnt == HOLD_LAST);

    // Preemption of the current owner while it still requests; the fixed-priority
    // build lets requester 0 take over OWN1 at once and never gives up OWN0.
    assign preempt0 = RR_EN && bus.req1 && hold_at_max;
    assign preempt1 = bus.req0 && (!RR_EN || hold_at_max);

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_btn) state <= IDLE;
        else            state <= state_next;
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1)
                    state_next = (next_owner(bus.req0, bus.req1, RR_EN, last_owner) == REQ1)
                                 ? OWN1 : OWN0;
            end
            OWN0: begin
                if (!bus.req0)    state_next = bus.req1 ? OWN1 : IDLE;
                else if (preempt0) state_next = OWN1;
            end
            OWN1: begin
                if (!bus.req1)    state_next = bus.req0 ? OWN0 : IDLE;
                else if (preempt1) state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold counter restarts on each new ownership; last_owner records who just left
    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            hold_cnt   <= '0;
            last_owner <= REQ1;
        end else begin
            if (state_next != state || state_next == IDLE)
                hold_cnt <= '0;
            else if (!hold_at_max)
                hold_cnt <= hold_cnt + 1'b1;
            if (state != IDLE && state_next != state)
                last_owner <= (state == OWN1) ? REQ1 : REQ0;
        end
    end

    // Read-valid flags follow the issuing requester, even if the grant moves on
    always_ff @(posedge clock) begin
        if (!reset_btn) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= issue0 && !bus.wren0;
            rvalid1_q <= issue1 && !bus.wren1;
        end
    end

    // Shared memory port: driven by the issuing owner, zero otherwise
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        wren_sel = 1'b0;
        if (issue0) begin
            addr_sel = bus.addr0;
            data_sel = bus.wdata0;
            wren_sel = bus.wren0;
        end else if (issue1) begin
            addr_sel = bus.addr1;
            data_sel = bus.wdata1;
            wren_sel = bus.wren1;
        end
    end

    assign bus.gnt0        = (state == OWN0);
    assign bus.gnt1        = (state == OWN1);
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata       = bus.mem_q;
    assign bus.mem_address = addr_sel;
    assign bus.mem_data_in = data_sel;
    assign bus.mem_wren    = wren_sel;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW          = 13;
    localparam int DW          = 32;
    localparam int MH          = 4;
    localparam int NV          = 14;
    localparam int RAND_CYCLES = 800;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_btn;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clock     (clock),
        .reset_btn (reset_btn),
        .bus       (bus)
    );

    // Memory contents are a fixed function of the address, returned one cycle later
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {~a, 6'h2A, a};
    endfunction

    always @(posedge clock) bus.mem_q <= memf(bus.mem_address);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 nobody, 0/1 requester; run: owned cycles so far minus one
    int              m_owner;
    int              m_run;
    int              m_last;
    bit              m_rv0, m_rv1;
    logic [AW-1:0]   m_prev_addr;

    task automatic model_port(output logic [AW-1:0] ea, output logic [DW-1:0] ed, output logic ew);
        ea = '0; ed = '0; ew = 1'b0;
        if (m_owner == 0 && bus.req0) begin
            ea = bus.addr0; ed = bus.wdata0; ew = bus.wren0;
        end else if (m_owner == 1 && bus.req1) begin
            ea = bus.addr1; ed = bus.wdata1; ew = bus.wren1;
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        int            nxt;
        bit            r0, r1, mine, other;
        model_port(ea, ed, ew);
        m_prev_addr = ea;
        r0 = bus.req0;
        r1 = bus.req1;
        if (!reset_btn) begin
            m_owner = -1; m_run = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
            return;
        end
        m_rv0 = (m_owner == 0) && r0 && !bus.wren0;
        m_rv1 = (m_owner == 1) && r1 && !bus.wren1;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = RR ? 1 - m_last : 0;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (!mine)       nxt = other ? 1 - m_owner : -1;
            else if (!other) nxt = m_owner;
            else if (RR)     nxt = (m_run == MH - 1) ? 1 - m_owner : m_owner;
            else             nxt = 0;
        end
        if (nxt >= 0 && nxt == m_owner) m_run = (m_run < MH - 1) ? m_run + 1 : m_run;
        else                            m_run = 0;
        if (m_owner >= 0 && nxt != m_owner) m_last = m_owner;
        m_owner = nxt;
    endtask

    task automatic check_model(input string tag);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        model_port(ea, ed, ew);
        chk({tag, ".gnt0"},   64'(bus.gnt0),        64'(m_owner == 0));
        chk({tag, ".gnt1"},   64'(bus.gnt1),        64'(m_owner == 1));
        chk({tag, ".addr"},   64'(bus.mem_address), 64'(ea));
        chk({tag, ".din"},    64'(bus.mem_data_in), 64'(ed));
        chk({tag, ".wren"},   64'(bus.mem_wren),    64'(ew));
        chk({tag, ".rvalid0"},64'(bus.rvalid0),     64'(m_rv0));
        chk({tag, ".rvalid1"},64'(bus.rvalid1),     64'(m_rv1));
        if (m_rv0 || m_rv1)
            chk({tag, ".rdata"}, 64'(bus.rdata), 64'(memf(m_prev_addr)));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rst, input logic r0, input logic r1,
                         input logic we0, input logic we1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clock);
        reset_btn  = rst;
        bus.req0   = r0;  bus.req1   = r1;
        bus.wren0  = we0; bus.wren1  = we1;
        bus.addr0  = a0;  bus.addr1  = a1;
        bus.wdata0 = d0;  bus.wdata1 = d1;
        #1;
    endtask

    task automatic step(input string tag, input logic rst, input logic r0, input logic r1,
                        input logic we0, input logic we1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        drive(rst, r0, r1, we0, we1, a0, a1, d0, d1);
        check_model(tag);
        model_edge();
    endtask

    typedef struct {
        logic          rst, r0, r1, we0, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          g0, g1, ew, v0, v1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, erd;
    } vec_t;

    vec_t tbl [NV];

    localparam logic [AW-1:0] A0 = 13'h0000;
    localparam logic [DW-1:0] D0 = 32'h0;

    initial begin
        // rst r0 r1 we0 we1 a0 a1 d0 d1 | g0 g1 wren rv0 rv1 addr din rdata
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,13'h0100,A0,D0,D0, 1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,13'h0100,A0,D0,D0, 1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,13'h0100,A0,D0,D0, 1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,A0,A0,D0,D0,       1'b1,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,A0,13'h0040,D0,D0, 1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,A0,13'h0040,D0,D0, 1'b0,1'b1,1'b0,1'b0,1'b0,13'h0040,D0,D0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,A0,A0,D0,D0,       1'b0,1'b1,1'b0,1'b0,1'b1,A0,D0,memf(13'h0040)};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,13'h1FFF,A0,32'hDEADBEEF,D0, 1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,13'h1FFF,A0,32'hDEADBEEF,D0, 1'b1,1'b0,1'b1,1'b0,1'b0,13'h1FFF,32'hDEADBEEF,D0};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,13'h1FFF,13'h0022,32'hDEADBEEF,D0, 1'b1,1'b0,1'b1,1'b0,1'b0,13'h1FFF,32'hDEADBEEF,D0};
        tbl[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0,13'h1FFF,13'h0022,32'hDEADBEEF,D0, 1'b1,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,A0,13'h0022,D0,D0, 1'b0,1'b1,1'b0,1'b0,1'b0,13'h0022,D0,D0};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,A0,A0,D0,D0,       1'b0,1'b1,1'b0,1'b0,1'b1,A0,D0,memf(13'h0022)};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,A0,A0,D0,D0,       1'b0,1'b0,1'b0,1'b0,1'b0,A0,D0,D0};

        // First edge puts the DUT into a known reset state; nothing to compare before it
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A0, A0, D0, D0);
        model_edge();

        // Directed vector table: reset hold/release, single read, write, handoff, idle
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].we0, tbl[i].we1,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            chk($sformatf("vec%0d.gnt0", i),    64'(bus.gnt0),        64'(tbl[i].g0));
            chk($sformatf("vec%0d.gnt1", i),    64'(bus.gnt1),        64'(tbl[i].g1));
            chk($sformatf("vec%0d.addr", i),    64'(bus.mem_address), 64'(tbl[i].ea));
            chk($sformatf("vec%0d.din", i),     64'(bus.mem_data_in), 64'(tbl[i].ed));
            chk($sformatf("vec%0d.wren", i),    64'(bus.mem_wren),    64'(tbl[i].ew));
            chk($sformatf("vec%0d.rvalid0", i), 64'(bus.rvalid0),     64'(tbl[i].v0));
            chk($sformatf("vec%0d.rvalid1", i), 64'(bus.rvalid1),     64'(tbl[i].v1));
            if (tbl[i].v0 || tbl[i].v1)
                chk($sformatf("vec%0d.rdata", i), 64'(bus.rdata), 64'(tbl[i].erd));
            model_edge();
        end

`ifdef ARB_RR_EN
        // Both requesters held high: ownership alternates in runs of MAX_HOLD cycles.
        // last_owner is 1 after the table, so requester 0 wins the opening tie.
        step("rr.idle", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'h0011, 13'h0012, D0, D0);
        for (int k = 0; k < 4 * MH; k++) begin
            step("rr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'h0011, 13'h0012, D0, D0);
            chk($sformatf("rr.alt%0d", k), 64'(bus.gnt0), 64'(((k / MH) % 2) == 0));
        end
`else
        // Requester 1 streams reads; requester 0 arrives and takes over on the next edge
        step("fp.idle", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0, 13'h0100, D0, D0);
        step("fp.s1",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0, 13'h0101, D0, D0);
        step("fp.T",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'h00AA, 13'h0102, D0, D0);
        chk("fp.T.gnt1", 64'(bus.gnt1), 64'(1));
        chk("fp.T.addr", 64'(bus.mem_address), 64'(13'h0102));
        step("fp.T1",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 13'h00AA, 13'h0103, D0, D0);
        chk("fp.T1.gnt0",    64'(bus.gnt0),    64'(1));
        chk("fp.T1.rvalid1", 64'(bus.rvalid1), 64'(1));
        chk("fp.T1.rdata",   64'(bus.rdata),   64'(memf(13'h0102)));
        step("fp.T2",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, D0, D0);
        chk("fp.T2.rvalid0", 64'(bus.rvalid0), 64'(1));
        chk("fp.T2.rdata",   64'(bus.rdata),   64'(memf(13'h00AA)));
`endif
        step("tail.idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, D0, D0);

        // Reset arriving while a read is in flight drops its rvalid
        step("rst.a", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0, 13'h0333, D0, D0);
        step("rst.b", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A0, 13'h0333, D0, D0);
        chk("rst.b.addr", 64'(bus.mem_address), 64'(13'h0333));
        step("rst.c", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A0, A0, D0, D0);
        chk("rst.c.rvalid1", 64'(bus.rvalid1), 64'(0));
        chk("rst.c.gnt1",    64'(bus.gnt1),    64'(0));

        // Randomized traffic, biased towards contention, with occasional resets
        for (int i = 0; i < RAND_CYCLES; i++) begin
            step("rand",
                 1'($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
